// File: rtl/syn_update_sequencer_if.sv
// -----------------------------------------------------------------------------
// syn_update_sequencer_if
//   Groups the control handshake and the synaptic SRAM access bus of the
//   synaptic-update sequencer.
//
//   Control (driven by the controller, seen by the sequencer):
//     START                   single-cycle sweep request
//     IS_TRAIN                training mode, sampled with START
//     SPI_GATE_ACTIVITY_sync  SPI owns the array; gates START
//     STALL                   arbiter hold; freezes the sweep
//   Status / SRAM bus (driven by the sequencer):
//     SEQ_SYNARRAY_CS/WE/ADDR SRAM chip select, write enable, word address
//     SEQ_PRE_NEUR_ADDR       current pre-neuron index
//     SEQ_POST_NEURON_ADDRESS first post neuron of the current word
//     BUSY, DONE              sweep in progress / completion pulse
//
//   Modports: master = controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface syn_update_sequencer_if;
   logic        START;
   logic        IS_TRAIN;
   logic        SPI_GATE_ACTIVITY_sync;
   logic        STALL;
   logic        SEQ_SYNARRAY_CS;
   logic        SEQ_SYNARRAY_WE;
   logic [15:0] SEQ_SYNARRAY_ADDR;
   logic [9:0]  SEQ_PRE_NEUR_ADDR;
   logic [9:0]  SEQ_POST_NEURON_ADDRESS;
   logic        BUSY;
   logic        DONE;

   modport master (
      output START, IS_TRAIN, SPI_GATE_ACTIVITY_sync, STALL,
      input  SEQ_SYNARRAY_CS, SEQ_SYNARRAY_WE, SEQ_SYNARRAY_ADDR,
             SEQ_PRE_NEUR_ADDR, SEQ_POST_NEURON_ADDRESS, BUSY, DONE
   );

   modport slave (
      input  START, IS_TRAIN, SPI_GATE_ACTIVITY_sync, STALL,
      output SEQ_SYNARRAY_CS, SEQ_SYNARRAY_WE, SEQ_SYNARRAY_ADDR,
             SEQ_PRE_NEUR_ADDR, SEQ_POST_NEURON_ADDRESS, BUSY, DONE
   );
endinterface

// File: rtl/syn_update_sequencer.sv
// -----------------------------------------------------------------------------
// syn_update_sequencer
//   Sweeps the whole N x M-word synaptic array once per sample. In training
//   mode every word is read (RD) and then written back (WR) with the updated
//   weights, which downstream logic forms from the read data. In inference
//   mode the sweep completes immediately without touching memory.
//
//   Parameters:
//     N  number of pre-synaptic neurons (array rows)
//     M  number of 32-bit words per row (4 post weights per word)
//   Ports:
//     CLK    rising-edge clock
//     RST_N  asynchronous active-low reset
//     bus    syn_update_sequencer_if.slave (control in, SRAM bus/status out)
// -----------------------------------------------------------------------------
module syn_update_sequencer #(
   parameter int N = 784,
   parameter int M = 8
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   syn_update_sequencer_if.slave        bus
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = (M > 1) ? $clog2(M) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(N - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(M - 1);

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q,   pre_d;
   logic [WW-1:0] word_q,  word_d;
   // Word address tracked as a running count: the sweep visits pre*M+word in
   // strictly increasing order, so an incrementer replaces the multiplier.
   logic [15:0]   addr_q,  addr_d;

   logic          last_word;
   logic          last_row;

   assign last_word = (word_q == WORD_LAST);
   assign last_row  = (pre_q  == PRE_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pre_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      word_d  = word_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (bus.START && !bus.SPI_GATE_ACTIVITY_sync) begin
               if (bus.IS_TRAIN) begin
                  state_d = RD;
                  pre_d   = '0;
                  word_d  = '0;
                  addr_d  = '0;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RD: begin
            if (!bus.STALL) state_d = WR;
         end
         WR: begin
            if (!bus.STALL) begin
               if (last_word && last_row) begin
                  // counters stay on the final word through FIN
                  state_d = FIN;
               end else begin
                  state_d = RD;
                  addr_d  = addr_q + 16'd1;
                  if (last_word) begin
                     word_d = '0;
                     pre_d  = pre_q + 1'b1;
                  end else begin
                     word_d = word_q + 1'b1;
                  end
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from registered state so reset clears them
   // without waiting for a clock. STALL only masks the SRAM strobes; the
   // SRAM keeps its read data while deselected.
   assign bus.BUSY                    = (state_q == RD) || (state_q == WR);
   assign bus.SEQ_SYNARRAY_CS         = bus.BUSY && !bus.STALL;
   assign bus.SEQ_SYNARRAY_WE         = (state_q == WR) && !bus.STALL;
   assign bus.DONE                    = (state_q == FIN);
   assign bus.SEQ_SYNARRAY_ADDR       = addr_q;
   assign bus.SEQ_PRE_NEUR_ADDR       = 10'(pre_q);
   assign bus.SEQ_POST_NEURON_ADDRESS = 10'({word_q, 2'b00});

endmodule
